triangle_intlv_ctrl: RTL and testbench
======================================

Name: triangle_intlv_ctrl

Overview:
Frame-level sequencer for the triangular shift-register interleaver (triangleSR, SIDE=128, 8256 bits). It accepts a frame as 32-bit words on a valid/ready stream and drives the write enables. It then issues a configurable number of diagonal shifts, and drains the frame with exactly one of four read modes (1, N1, N2 or N3 bits per beat) under downstream backpressure. It sits between the bit-stream source and the triangleSR instance and guarantees at most one triangleSR op-enable per cycle.

Parameters:
SIDE, 128, triangle side; TOTAL_BITS = SIDE*(SIDE+1)/2 = 8256
N1, 38, bits per rdN1 beat
N2, 11, bits per rdN2 beat
N3, 3, bits per rdN3 beat
WORDS, TOTAL_BITS/32 = 258, fill beats per frame (TOTAL_BITS must be a multiple of 32; elaboration-time check)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  frame start pulse; sampled only in IDLE
abort  in  1  abandon current frame
cfg_rd_mode  in  2  0=RD1, 1=RDN1, 2=RDN2, 3=RDN3; latched on accepted start
cfg_diag_num  in  7  diagonal shifts after fill (0..127); latched on accepted start
in_valid  in  1  input word valid
in_data  in  32  input word
in_ready  out  1  controller accepts word
wr32_en  out  1  triangleSR 32-bit write
wr32_data  out  32  = in_data
diag_shift_en  out  1  triangleSR diagonal shift
rd1_en, rdN1_en, rdN2_en, rdN3_en  out  1 each  triangleSR read enables
out_ready  in  1  downstream can accept a read beat
rd_bits  out  6  valid bits in current read beat (meaningful when any rd*_en=1)
rd_last  out  1  current read beat is final beat of frame
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after final read beat

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, all counters 0, latched cfg 0, all outputs 0.
- States: IDLE, FILL, DIAG, DRAIN. The FSM and counters are registered. All enables are combinational from state and handshakes, so latency is zero.
- IDLE: start=1 and abort=0 -> latch cfg, clear counters, go to FILL next cycle. start is ignored in all other states.
- FILL: in_ready=1. wr32_en = in_valid & in_ready. Each wr32 increments wcnt (9 b). When wcnt==WORDS-1 and wr32_en=1, go to DIAG if cfg_diag_num!=0, else DRAIN.
- DIAG: diag_shift_en=1 every cycle, with no backpressure. dcnt counts 0..cfg_diag_num-1, then go to DRAIN.
- DRAIN: the selected enable = out_ready; the others stay 0.
  - rcnt (14 b) counts beats up to BEATS(mode)-1, with BEATS = ceil(8256/n): RD1=8256, RDN1=218, RDN2=751, RDN3=2752.
  - rd_bits = n, except on the final beat, where it is 8256 - n*(BEATS-1): RD1 1, RDN1 10, RDN2 6, RDN3 3.
  - rd_last = enable & (rcnt==BEATS-1). On the final beat, go to IDLE and assert done the next cycle.
- rd_bits=0 when no read enable is asserted.
- abort=1 has priority in any state: no enable is asserted that cycle, in_ready=0, the next state is IDLE, counters clear, and done is not pulsed. abort in IDLE is a no-op.
- Invariant: wr32_en + diag_shift_en + rd*_en together are at most 1 (one-hot-or-zero) every cycle.
- in_valid outside FILL: the word is not consumed (in_ready=0).
- Back-to-back frames: start may be accepted in the same cycle done is high, since the state is already IDLE.

Decomposition:
- Package triangle_intlv_pkg:
  - state enum (IDLE/FILL/DIAG/DRAIN), rd-mode enum.
  - TOTAL_BITS, WORDS constants.
  - Functions beats(n) and last_bits(n).
- No sub-module required. The counters and FSM stay inline (about 200 lines).

Test Plan:
- Reset: hold rst_n=0 for 3 clk with in_valid=1 and start=1 -> all outputs 0, busy=0.
- Mode RD1, diag=0, in_valid always 1, out_ready always 1:
  - 258 consecutive wr32_en, then 8256 rd1_en with rd_bits=1.
  - rd_last on beat 8256; done 1 cycle later; total busy cycles 8514.
- Mode RDN1, diag=5, out_ready toggling 1/0:
  - 5 diag_shift_en cycles between last wr32 and first rdN1_en.
  - 218 rdN1_en beats only on out_ready=1 cycles; final rd_bits=10.
- Mode RDN2, in_valid gapped every 3rd cycle:
  - wr32_en only on valid cycles, wcnt reaches 258.
  - 751 beats; final rd_bits=6; rdN3/rd1/rdN1 never asserted.
- Abort mid-FILL at word 100 and mid-DRAIN at RDN3 beat 1000:
  - next cycle IDLE, busy=0, no done.
  - a new start runs a full frame of 258 words.
- Protocol checks throughout: enable one-hot-or-zero, start ignored while busy (cfg_rd_mode change mid-frame has no effect), done coincident-cycle restart accepted.

Source files
------------

// File: rtl/triangle_intlv_pkg.sv
// Shared types, frame geometry and beat arithmetic for the triangleSR frame sequencer.
package triangle_intlv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DIAG  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RD1  = 2'd0,
        RDN1 = 2'd1,
        RDN2 = 2'd2,
        RDN3 = 2'd3
    } rd_mode_t;

    localparam int SIDE_DEF   = 128;
    localparam int TOTAL_BITS = SIDE_DEF * (SIDE_DEF + 1) / 2;
    localparam int WORDS      = TOTAL_BITS / 32;

    function automatic int beats(input int total, input int n);
        return (total + n - 1) / n;
    endfunction

    // Width of the short tail beat that finishes the frame.
    function automatic int last_bits(input int total, input int n);
        return total - n * (beats(total, n) - 1);
    endfunction

endpackage

// File: rtl/triangle_intlv_ctrl.sv
// Frame sequencer for triangleSR: fill by 32-bit words, optional diagonal shifts,
// then drain in one read mode under downstream backpressure.
module triangle_intlv_ctrl
    import triangle_intlv_pkg::*;
#(
    parameter int SIDE = SIDE_DEF,
    parameter int N1   = 38,
    parameter int N2   = 11,
    parameter int N3   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  cfg_rd_mode,
    input  logic [6:0]  cfg_diag_num,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        wr32_en,
    output logic [31:0] wr32_data,
    output logic        diag_shift_en,
    output logic        rd1_en,
    output logic        rdN1_en,
    output logic        rdN2_en,
    output logic        rdN3_en,
    input  logic        out_ready,
    output logic [5:0]  rd_bits,
    output logic        rd_last,
    output logic        busy,
    output logic        done
);

    localparam int TOTAL = SIDE * (SIDE + 1) / 2;
    localparam int NWORD = TOTAL / 32;

    if ((TOTAL % 32) != 0) begin : g_total_check
        $error("triangle size must be a multiple of 32 bits");
    end

    localparam logic [8:0]  WORDS_M1 = 9'(NWORD - 1);
    localparam logic [13:0] B1_M1    = 14'(beats(TOTAL, 1) - 1);
    localparam logic [13:0] BN1_M1   = 14'(beats(TOTAL, N1) - 1);
    localparam logic [13:0] BN2_M1   = 14'(beats(TOTAL, N2) - 1);
    localparam logic [13:0] BN3_M1   = 14'(beats(TOTAL, N3) - 1);
    localparam logic [5:0]  L1       = 6'(last_bits(TOTAL, 1));
    localparam logic [5:0]  LN1      = 6'(last_bits(TOTAL, N1));
    localparam logic [5:0]  LN2      = 6'(last_bits(TOTAL, N2));
    localparam logic [5:0]  LN3      = 6'(last_bits(TOTAL, N3));

    state_t      state;
    rd_mode_t    mode_q;
    logic [6:0]  diag_q;
    logic [8:0]  wcnt;
    logic [6:0]  dcnt;
    logic [13:0] rcnt;

    logic [13:0] beats_m1;
    logic [5:0]  n_bits;
    logic [5:0]  tail_bits;
    logic        rd_fire;
    logic        final_beat;

    always_comb begin
        beats_m1  = B1_M1;
        n_bits    = 6'd1;
        tail_bits = L1;
        case (mode_q)
            RD1:  begin beats_m1 = B1_M1;  n_bits = 6'd1;      tail_bits = L1;  end
            RDN1: begin beats_m1 = BN1_M1; n_bits = 6'(N1);    tail_bits = LN1; end
            RDN2: begin beats_m1 = BN2_M1; n_bits = 6'(N2);    tail_bits = LN2; end
            RDN3: begin beats_m1 = BN3_M1; n_bits = 6'(N3);    tail_bits = LN3; end
            default: ;
        endcase
    end

    // Enables are combinational so the triangleSR sees the op in the handshake cycle;
    // abort masks every enable, which keeps them one-hot-or-zero.
    always_comb begin
        in_ready      = (state == FILL) && !abort;
        wr32_en       = in_ready && in_valid;
        wr32_data     = in_data;
        diag_shift_en = (state == DIAG) && !abort;
        rd_fire       = (state == DRAIN) && !abort && out_ready;
        rd1_en        = rd_fire && (mode_q == RD1);
        rdN1_en       = rd_fire && (mode_q == RDN1);
        rdN2_en       = rd_fire && (mode_q == RDN2);
        rdN3_en       = rd_fire && (mode_q == RDN3);
        final_beat    = (rcnt == beats_m1);
        rd_last       = rd_fire && final_beat;
        rd_bits       = rd_fire ? (final_beat ? tail_bits : n_bits) : 6'd0;
        busy          = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode_q <= RD1;
            diag_q <= 7'd0;
            wcnt   <= 9'd0;
            dcnt   <= 7'd0;
            rcnt   <= 14'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                wcnt  <= 9'd0;
                dcnt  <= 7'd0;
                rcnt  <= 14'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            mode_q <= rd_mode_t'(cfg_rd_mode);
                            diag_q <= cfg_diag_num;
                            wcnt   <= 9'd0;
                            dcnt   <= 7'd0;
                            rcnt   <= 14'd0;
                            state  <= FILL;
                        end
                    end
                    FILL: begin
                        if (wr32_en) begin
                            if (wcnt == WORDS_M1) begin
                                wcnt  <= 9'd0;
                                state <= (diag_q != 7'd0) ? DIAG : DRAIN;
                            end else begin
                                wcnt <= wcnt + 9'd1;
                            end
                        end
                    end
                    DIAG: begin
                        if (dcnt == diag_q - 7'd1) begin
                            dcnt  <= 7'd0;
                            state <= DRAIN;
                        end else begin
                            dcnt <= dcnt + 7'd1;
                        end
                    end
                    DRAIN: begin
                        if (rd_fire) begin
                            if (final_beat) begin
                                rcnt  <= 14'd0;
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                rcnt <= rcnt + 14'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_triangle_intlv_ctrl.sv
// Randomized bench for triangle_intlv_ctrl with a frame-level behavioural model.
module tb_triangle_intlv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, in_valid, out_ready;
    logic [1:0]  cfg_rd_mode;
    logic [6:0]  cfg_diag_num;
    logic [31:0] in_data, wr32_data;
    logic        in_ready, wr32_en, diag_shift_en, rd1_en, rdN1_en, rdN2_en, rdN3_en;
    logic [5:0]  rd_bits;
    logic        rd_last, busy, done;

    always #5 clk = ~clk;

    triangle_intlv_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_rd_mode(cfg_rd_mode), .cfg_diag_num(cfg_diag_num),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr32_en(wr32_en), .wr32_data(wr32_data), .diag_shift_en(diag_shift_en),
        .rd1_en(rd1_en), .rdN1_en(rdN1_en), .rdN2_en(rdN2_en), .rdN3_en(rdN3_en),
        .out_ready(out_ready), .rd_bits(rd_bits), .rd_last(rd_last),
        .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Hand-derived frame facts: beats per mode and width of the closing beat.
    int BEATS_LIT [4] = '{8256, 218, 751, 2752};
    int LAST_LIT  [4] = '{1, 10, 6, 3};

    function automatic int width_of(input int m);
        case (m)
            0: return 1;
            1: return 38;
            2: return 11;
            default: return 3;
        endcase
    endfunction

    // Behavioural model: phase 0 idle, 1 fill, 2 diag, 3 drain, plus progress counts.
    int m_phase = 0, m_words = 0, m_diagc = 0, m_beats = 0, m_mode = 0, m_diag = 0;
    bit m_done = 0, m_chk_len = 0;
    bit chk_busy_len = 0;
    int fr_wr = 0, fr_diag = 0, fr_rd = 0, fr_busy = 0, fr_last_bits = -1;

    initial begin : compare
        int n, nb, e_bits;
        bit e_ir, e_wr, e_dg, e_rd, fin;
        logic [3:0] e_rdv;
        logic [15:0] e_vec, a_vec;
        @(posedge clk);
        forever begin
            @(negedge clk);
            n      = width_of(m_mode);
            nb     = (8256 + n - 1) / n;
            e_ir   = (m_phase == 1) && !abort;
            e_wr   = e_ir && in_valid;
            e_dg   = (m_phase == 2) && !abort;
            e_rd   = (m_phase == 3) && !abort && out_ready;
            e_rdv  = e_rd ? (4'b1000 >> m_mode) : 4'b0000;
            fin    = (m_beats == nb - 1);
            e_bits = e_rd ? (fin ? 8256 - n * (nb - 1) : n) : 0;
            e_vec  = {e_ir, e_wr, e_dg, e_rdv, e_rd && fin, m_phase != 0, m_done, 6'(e_bits)};
            a_vec  = {in_ready, wr32_en, diag_shift_en, rd1_en, rdN1_en, rdN2_en, rdN3_en,
                      rd_last, busy, done, rd_bits};
            chk("outputs{ir,wr,dg,rd1,n1,n2,n3,last,busy,done,bits}", 32'(a_vec), 32'(e_vec));
            if (wr32_en === 1'b1) chk("wr32_data", wr32_data, in_data);
            chk("enable_onehot",
                32'($countones({wr32_en, diag_shift_en, rd1_en, rdN1_en, rdN2_en, rdN3_en}) <= 1),
                32'd1);

            if (wr32_en === 1'b1) fr_wr++;
            if (diag_shift_en === 1'b1) fr_diag++;
            if ((rd1_en | rdN1_en | rdN2_en | rdN3_en) === 1'b1) fr_rd++;
            if (rd_last === 1'b1) fr_last_bits = int'(rd_bits);
            if (busy === 1'b1) fr_busy++;

            if (done === 1'b1) begin
                chk("frame_words", 32'(fr_wr), 32'd258);
                chk("frame_diag_shifts", 32'(fr_diag), 32'(m_diag));
                chk("frame_read_beats", 32'(fr_rd), 32'(BEATS_LIT[m_mode]));
                chk("frame_last_bits", 32'(fr_last_bits), 32'(LAST_LIT[m_mode]));
                if (m_chk_len)
                    chk("frame_busy_cycles", 32'(fr_busy), 32'(258 + m_diag + BEATS_LIT[m_mode]));
            end

            // advance the model to the state after the coming clock edge
            if (!rst_n) begin
                m_phase = 0; m_words = 0; m_diagc = 0; m_beats = 0;
                m_mode = 0; m_diag = 0; m_done = 0;
            end else begin
                m_done = 0;
                if (abort) begin
                    m_phase = 0; m_words = 0; m_diagc = 0; m_beats = 0;
                end else begin
                    case (m_phase)
                        0: if (start) begin
                            m_mode = int'(cfg_rd_mode); m_diag = int'(cfg_diag_num);
                            m_chk_len = chk_busy_len;
                            m_phase = 1; m_words = 0; m_diagc = 0; m_beats = 0;
                            fr_wr = 0; fr_diag = 0; fr_rd = 0; fr_busy = 0; fr_last_bits = -1;
                        end
                        1: if (e_wr) begin
                            m_words++;
                            if (m_words == 258) m_phase = (m_diag != 0) ? 2 : 3;
                        end
                        2: begin
                            m_diagc++;
                            if (m_diagc == m_diag) m_phase = 3;
                        end
                        default: if (e_rd) begin
                            m_beats++;
                            if (m_beats == nb) begin m_phase = 0; m_done = 1; end
                        end
                    endcase
                end
            end
        end
    end

    int cyc = 0;
    int pat_valid = 0;  // 0 always, 1 gap every 3rd cycle, 2 random
    int pat_ready = 0;  // 0 always, 1 toggle, 2 random

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        in_data   = $urandom;
        in_valid  = (pat_valid == 0) ? 1'b1 : (pat_valid == 1) ? (cyc % 3 != 0) : 1'($urandom_range(0, 1));
        out_ready = (pat_ready == 0) ? 1'b1 : (pat_ready == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
    endtask

    task automatic start_frame(input int mode, input int diag);
        start        = 1'b1;
        cfg_rd_mode  = 2'(mode);
        cfg_diag_num = 7'(diag);
        step();
        start        = 1'b0;
        cfg_rd_mode  = 2'($urandom);
        cfg_diag_num = 7'($urandom);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40000; i++) begin
            step();
            if (done === 1'b1) begin ok = 1; break; end
        end
        chk("done_within_budget", 32'(ok), 32'd1);
    endtask

    initial begin : stim
        bit ok;
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_data = 32'h0; cfg_rd_mode = 2'd3; cfg_diag_num = 7'd9;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            32'({in_ready, wr32_en, diag_shift_en, rd1_en, rdN1_en, rdN2_en, rdN3_en,
                 rd_last, busy, done, rd_bits}), 32'd0);
        rst_n = 1'b1; start = 1'b0;
        step();

        // RD1, no diagonal shifts, full throughput
        pat_valid = 0; pat_ready = 0; chk_busy_len = 1;
        start_frame(0, 0);
        chk_busy_len = 0;
        wait_done();

        // RDN1 restarted in the done cycle; toggling backpressure; ignored mid-frame start
        pat_ready = 1;
        start_frame(1, 5);
        repeat (50) step();
        start = 1'b1; cfg_rd_mode = 2'd3; cfg_diag_num = 7'd99;
        step();
        start = 1'b0;
        wait_done();

        // RDN2 with gapped input and random backpressure
        pat_valid = 1; pat_ready = 2;
        start_frame(2, int'($urandom_range(1, 127)));
        wait_done();

        // abort during fill after 100 words
        pat_valid = 2;
        start_frame(3, 20);
        for (int i = 0; i < 2000 && fr_wr < 100; i++) step();
        chk("reached_word_100", 32'(fr_wr), 32'd100);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_fill_busy", 32'(busy), 32'd0);
        chk("abort_fill_done", 32'(done), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();

        // abort during RDN3 drain at beat 1000
        start_frame(3, 7);
        for (int i = 0; i < 8000 && fr_rd < 1000; i++) step();
        chk("reached_beat_1000", 32'(fr_rd), 32'd1000);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_drain_busy", 32'(busy), 32'd0);
        chk("abort_drain_done", 32'(done), 32'd0);
        step();

        // fresh full frame after the aborts
        start_frame(3, int'($urandom_range(0, 127)));
        wait_done();
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
